// File: rtl/reg_trace_dump_pkg.sv
// Shared definitions for the register trace dumper: FSM states, the dump
// length and the register numbers that make up the dump sequence.
package reg_trace_dump_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  localparam int REG_IDX_W   = 5;
  localparam int IDX_W       = 4;
  localparam int ENTRY_COUNT = 12;
  localparam int NUM_S_REGS  = 8;

  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(ENTRY_COUNT - 1);
  localparam logic [REG_IDX_W-1:0] REG_S0   = 5'd16;
  localparam logic [REG_IDX_W-1:0] REG_T0   = 5'd8;

  // $s0..$s7 first, then $t0..$t3; positions past the end map to $zero.
  function automatic logic [REG_IDX_W-1:0] seq_entry(input int pos);
    if (pos < NUM_S_REGS)
      return REG_S0 + REG_IDX_W'(pos);
    else if (pos < ENTRY_COUNT)
      return REG_T0 + REG_IDX_W'(pos - NUM_S_REGS);
    else
      return '0;
  endfunction

endpackage

// File: rtl/reg_trace_dump_if.sv
// Register-file read port plus the trace-record stream of the dumper.
interface reg_trace_dump_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
);
  logic [4:0]        rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [4:0]        out_addr;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  out_cycle;

  modport master (
    output rd_addr,
    input  rd_data,
    output out_valid,
    input  out_ready,
    output out_addr,
    output out_data,
    output out_cycle
  );

  modport slave (
    input  rd_addr,
    output rd_data,
    input  out_valid,
    output out_ready,
    input  out_addr,
    input  out_data,
    input  out_cycle
  );
endinterface

// File: rtl/reg_trace_dump_seq_rom.sv
// Combinational lookup from dump position to register number.
module trace_seq_rom
  import reg_trace_dump_pkg::*;
(
  input  logic [IDX_W-1:0]     idx,
  output logic [REG_IDX_W-1:0] reg_num
);

  logic [REG_IDX_W-1:0] seq_table [1 << IDX_W];

  for (genvar gi = 0; gi < (1 << IDX_W); gi++) begin : g_table
    assign seq_table[gi] = seq_entry(gi);
  end

  assign reg_num = seq_table[idx];

endmodule

// File: rtl/reg_trace_dump.sv
// Dumps a fixed set of registers as stamped trace records over a
// valid/ready stream, reading through a dedicated register-file port.
module reg_trace_dump
  import reg_trace_dump_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  reg_trace_dump_if.master  bus,
  output logic              busy,
  output logic              done
);

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg;
  logic [CNT_W-1:0]      stamp_reg;
  logic [IDX_W-1:0]      idx_reg;
  logic [REG_IDX_W-1:0]  addr_reg;
  logic [DATA_W-1:0]     data_reg;
  logic [REG_IDX_W-1:0]  seq_addr;
  logic                  accept;

  trace_seq_rom u_seq_rom (
    .idx     (idx_reg),
    .reg_num (seq_addr)
  );

  assign accept = (state_reg == ST_SEND) && bus.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_reg <= ST_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_READ;
      ST_READ: state_next = ST_SEND;
      ST_SEND: if (accept) state_next = (idx_reg == LAST_IDX) ? ST_FIN : ST_READ;
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.rd_addr   = '0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state_reg)
      ST_READ: begin
        bus.rd_addr = seq_addr;
        busy        = 1'b1;
      end
      ST_SEND: begin
        bus.out_valid = 1'b1;
        busy          = 1'b1;
      end
      ST_FIN:  done = 1'b1;
      default: ;
    endcase
  end

  // Counter free-runs; the snapshot stamp is the counter value in the
  // cycle where start is sampled, shared by every record of the dump.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg   <= '0;
      stamp_reg <= '0;
      idx_reg   <= '0;
      addr_reg  <= '0;
      data_reg  <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            stamp_reg <= cnt_reg;
            idx_reg   <= '0;
          end
        end
        ST_READ: begin
          addr_reg <= seq_addr;
          data_reg <= bus.rd_data;
        end
        ST_SEND: begin
          if (accept && (idx_reg != LAST_IDX))
            idx_reg <= idx_reg + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.out_addr  = addr_reg;
  assign bus.out_data  = data_reg;
  assign bus.out_cycle = stamp_reg;

endmodule

// File: tb/tb_reg_trace_dump.sv
// Directed bench for reg_trace_dump: full dumps, back-pressure, ignored
// restarts, mid-dump reset and counter wrap.
module tb_reg_trace_dump;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy, done;

  int errors = 0;
  int checks = 0;
  int cyc;

  logic [31:0] regs [32];
  int exp_addr [12] = '{16, 17, 18, 19, 20, 21, 22, 23, 8, 9, 10, 11};

  reg_trace_dump_if #(.DATA_W(32), .CNT_W(32)) bus ();

  reg_trace_dump #(.DATA_W(32), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bus   (bus),
    .busy  (busy),
    .done  (done)
  );

  assign bus.rd_data = regs[bus.rd_addr];

  always #5 clk = ~clk;

  // Bench-side cycle number: equals the DUT counter value within a cycle.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Entered at the falling edge inside the first READ cycle (t=0).
  task automatic run_dump(input logic [31:0] stamp, input int stall_rec,
                          input bit poke, output int done_cyc);
    int rec = 0;
    int stall = 0;
    int dones = 0;
    int done_t = -1;
    int first_v = -1;
    int after = 0;
    done_cyc = -1;
    for (int t = 0; t < 80 && after < 4; t++) begin
      if (bus.out_valid && first_v < 0) first_v = t;
      if (bus.out_valid) begin
        if (rec < 12) begin
          chk("rec_addr", bus.out_addr, exp_addr[rec]);
          chk("rec_data", bus.out_data, 32'(exp_addr[rec]) * 32'h11111111);
          chk("rec_cycle", bus.out_cycle, stamp);
          if (exp_addr[rec] == 17) chk("addr17_data", bus.out_data, 32'h22222221);
        end
        if (rec == stall_rec && stall < 5) begin
          bus.out_ready = 1'b0;
          stall++;
        end else begin
          bus.out_ready = 1'b1;
          rec++;
        end
      end else begin
        bus.out_ready = 1'b1;
      end
      if (done) begin
        dones++;
        done_t = t;
        done_cyc = cyc;
        chk("fin_busy", busy, 0);
      end
      if (dones > 0) after++;
      start = poke && (busy || done);
      @(negedge clk);
    end
    start = 1'b0;
    bus.out_ready = 1'b1;
    chk("record_count", rec, 12);
    chk("done_count", dones, 1);
    chk("first_valid_latency", first_v, 1);
    chk("done_offset", done_t, 24 + stall);
    chk("idle_after_dump", busy, 0);
    $display("dump stamp=0x%08h records=%0d stall=%0d done_offset=%0d", stamp, rec, stall, done_t);
  endtask

  initial begin
    int dc;
    int found;
    logic [31:0] s;

    for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h11111111;
    bus.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_addr", bus.rd_addr, 0);
    chk("rst_out_addr", bus.out_addr, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_cycle", bus.out_cycle, 0);

    // Basic dump: start sampled in cycle 5, FIN lands in cycle 30.
    reset = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("read_rd_addr", bus.rd_addr, 16);
    chk("read_busy", busy, 1);
    chk("read_valid", bus.out_valid, 0);
    run_dump(32'd5, -1, 1'b0, dc);
    chk("done_cycle", dc, 30);
    chk("idle_rd_addr", bus.rd_addr, 0);

    // Back-pressure on record 3 with start poked while busy and in FIN.
    repeat (2) @(negedge clk);
    s = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_dump(s, 3, 1'b1, dc);

    // Reset while record 6 is on offer.
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int t = 0; t < 40; t++) begin
      if (bus.out_valid && bus.out_addr == 5'd22) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    chk("reach_rec6", found, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_rd_addr", bus.rd_addr, 0);
    chk("mid_rst_out_addr", bus.out_addr, 0);
    chk("mid_rst_out_data", bus.out_data, 0);
    chk("mid_rst_out_cycle", bus.out_cycle, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("no_resume_busy", busy, 0);
    chk("no_resume_valid", bus.out_valid, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_dump(32'd4, -1, 1'b0, dc);

    // Counter wrap: 0xFFFFFFFE plus three cycles gives stamp 1.
    @(negedge clk);
    force dut.cnt_reg = 32'hFFFFFFFE;
    #1;
    release dut.cnt_reg;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_dump(32'h00000001, -1, 1'b0, dc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
